mux_rr_arbiter: RTL
===================

# mux_rr_arbiter

Round-robin arbiter and sequencer for the team's gate-level 8:1 single-bit mux (`muxGL`). It shares that mux between eight requesters. The arbiter:
- accepts per-requester request lines;
- grants exactly one owner at a time;
- drives the mux select from the registered grant;
- presents the owner's data bit as a qualified serial output.

It bounds ownership with a hold counter so that no requester can starve the others.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive granted cycles while other requests are pending. Legal range 2..255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `req` in 8: request per requester; level-sensitive; held high while the requester wants the mux.
- `din` in 8: data bit per requester; routed through the mux.
- `gnt` out 8: one-hot grant, registered; all zero when idle.
- `sel` out 3: registered mux select; equals the index of the set bit of `gnt`.
- `valid` out 1: high while a grant is active.
- `y` out 1: `din[sel]` when `valid`=1, else 0.

## Operation
- States:
  - IDLE: `gnt`=0, `valid`=0.
  - GRANT: one-hot `gnt`, `valid`=1.
- Round-robin pointer `ptr` (3 bits): the search starts at `ptr` and wraps 7→0. After every new grant to index k, `ptr` becomes (k+1) mod 8.
- Hold counter `cnt` (8 bits):
  - Cleared on every new grant.
  - Increments each GRANT cycle.
  - Saturates at `MAX_HOLD`-1.
- Transitions and winner selection are evaluated each edge:
  - IDLE, `req`=0: stay IDLE.
  - IDLE, `req`≠0: go to GRANT; winner is the first set `req` bit at or after `ptr`.
  - GRANT, owner `req` low, no other `req`: go to IDLE; `gnt`, `valid` → 0; `sel` holds its last value.
  - GRANT, owner `req` low, others pending: hand off directly to the next winner (search from `ptr`). There is no idle bubble.
  - GRANT, owner `req` high, `cnt`=`MAX_HOLD`-1, others pending: preempt and hand off to the next winner. The owner may re-win only after a full rotation.
  - GRANT, owner `req` high, no other pending: owner keeps the grant indefinitely; `cnt` stays saturated.
- The owner is never a candidate in its own handoff search. Because `ptr` is owner+1, the owner has the lowest priority in that search.
- The search ignores `req` bits that change in the same cycle only through the registered decision. All inputs are sampled at the edge.

## Timing
- Reset (`rst_n`=0 at an edge) forces on the next edge:
  - state IDLE;
  - `gnt`=0, `sel`=0, `valid`=0, `y`=0;
  - `ptr`=0, `cnt`=0.
- Reset mid-grant drops the grant at that edge, with no completion cycle.
- Grant latency: `req` sampled high at edge n → `gnt` and `valid` high after edge n.
- Release latency: owner `req` sampled low at edge n → grant changes or clears after edge n.
- `y` is combinational from `din` and registered `sel` through `muxGL`, so it has the mux propagation delay only. It is gated to 0 when `valid`=0.
- Preemption: with others pending throughout, the owner holds exactly `MAX_HOLD` cycles.
- `gnt` is always one-hot or zero, and `sel` equals its index whenever `valid`=1. Both are assertable invariants.

## Structure
- Shared package holds:
  - `N_REQ`=8;
  - `SEL_W`=3;
  - `CNT_W`=8;
  - the state encoding (IDLE=0, GRANT=1).
- Sub-module: one instance of the existing `muxGL` (`in`=`din`, `sel`=`sel`, output ANDed with `valid` to form `y`).
- The rotate-priority search (8-bit masked priority encoder from `ptr`) stays inline as a function. It needs no separate module.

## Test plan
- Reset then `req`=8'h00 for 5 cycles → `gnt`=0, `valid`=0, `y`=0, `sel`=0 throughout.
- Simultaneous request and data pattern:
  - Stimulus: `req`=8'h81 with `ptr`=0; `din`=8'b10101010.
  - Grant: `gnt`=8'h01 one cycle later; `sel`=0, `y`=0.
  - Release: drop `req[0]` → next cycle `gnt`=8'h80, `sel`=7, `y`=1, with no idle cycle.
- Starvation bound:
  - Stimulus: `req`=8'hFF held, `MAX_HOLD`=4.
  - Response: grants rotate 0,1,2,…,7,0.
  - Each grant lasts exactly 4 cycles.
  - `sel` tracks the grant index.
- Lone owner, `MAX_HOLD`=4: `req`=8'h08 held 20 cycles → `gnt`=8'h08 the entire time; no preemption.
- Wrap-around:
  - Stimulus: owner 6 releases while `req`=8'h03.
  - Response: `gnt`=8'h01 next cycle; `ptr`=1 afterward.
  - Follow-up: a later tie with `req`=8'h03 picks requester 1.
- Mid-grant reset: `rst_n`=0 for one edge during `gnt`=8'h20 → `gnt`=0, `valid`=0, `ptr`=0 after that edge; the next grant search starts at 0.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared widths and state encoding for the round-robin mux arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_rr_arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/mux_rr_arbiter_muxgl.sv
// Gate-level 8:1 single-bit mux: decoded select ANDed with inputs, OR-reduced.
// Latency: combinational.
// Backpressure: none.
module muxGL (
    input  logic [7:0] in,
    input  logic [2:0] sel,
    output logic       out
);

    logic [7:0] dec;

    for (genvar i = 0; i < 8; i++) begin : g_dec
        assign dec[i] = (sel == 3'(i));
    end

    assign out = |(dec & in);

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 mux between eight level-sensitive requesters.
// Latency: grant/release visible one edge after req is sampled; y is combinational from din.
// Backpressure: owner holds at most MAX_HOLD cycles while others wait; lone owner holds indefinitely.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             valid,
    output logic             y
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;

    logic [N_REQ-1:0] others;
    logic             others_pend;
    logic             owner_req;
    logic             grab;
    logic             drop;
    logic [SEL_W-1:0] win;
    logic             mux_out;

    // First set bit of r at or after index p, wrapping 7->0. The reverse scan
    // leaves the closest hit to p as the final assignment.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [SEL_W-1:0] p);
        logic [SEL_W-1:0] idx;
        rr_pick = p;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = p + SEL_W'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    // The owner is excluded from its own handoff search.
    assign others      = req & ~gnt;
    assign others_pend = |others;
    assign owner_req   = |(req & gnt);

    // Decide whether this edge makes a new grant, clears to idle, or keeps the owner.
    always_comb begin
        grab = 1'b0;
        drop = 1'b0;
        win  = rr_pick(req, ptr);
        case (state)
            IDLE: begin
                grab = |req;
            end
            GRANT: begin
                win = rr_pick(others, ptr);
                if (!owner_req) begin
                    grab = others_pend;
                    drop = !others_pend;
                end else if (others_pend && cnt == CNT_MAX) begin
                    grab = 1'b1;
                end
            end
            default: begin
                grab = 1'b0;
            end
        endcase
    end

    // Registered grant, select, pointer and hold counter; sel keeps its value when going idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= '0;
            valid <= 1'b0;
            ptr   <= '0;
            cnt   <= '0;
        end else if (grab) begin
            state <= GRANT;
            gnt   <= N_REQ'(1) << win;
            sel   <= win;
            valid <= 1'b1;
            ptr   <= win + SEL_W'(1);
            cnt   <= '0;
        end else if (drop) begin
            state <= IDLE;
            gnt   <= '0;
            valid <= 1'b0;
            cnt   <= '0;
        end else if (state == GRANT && cnt != CNT_MAX) begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

    muxGL u_mux (
        .in  (din),
        .sel (sel),
        .out (mux_out)
    );

    assign y = mux_out & valid;

endmodule
